// File: rtl/mac_vec_pipe_if.sv
// mac_vec_pipe_if
// Handshake bus of the mac_vec_pipe dot-product engine.
//   Input side : in_vld/in_rdy handshake carrying a signed in1/in2 pair.
//   Output side: out_vld/out_rdy handshake carrying the signed out_data
//                result and its out_ovf flag.
// Modports:
//   master - the producer/consumer around the engine (drives pairs, accepts results)
//   slave  - the engine itself
// IN_W and ACC_W must match the parameters of the attached mac_vec_pipe.
interface mac_vec_pipe_if #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 26
);
    logic                    in_vld;
    logic                    in_rdy;
    logic signed [IN_W-1:0]  in1;
    logic signed [IN_W-1:0]  in2;
    logic                    out_vld;
    logic                    out_rdy;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_ovf;

    modport master (
        output in_vld, in1, in2, out_rdy,
        input  in_rdy, out_vld, out_data, out_ovf
    );

    modport slave (
        input  in_vld, in1, in2, out_rdy,
        output in_rdy, out_vld, out_data, out_ovf
    );
endinterface

// File: rtl/mac_vec_pipe.sv
// mac_vec_pipe
// Pipelined signed multiply-accumulate engine producing one dot product per
// VEC_LEN element pairs. Three stages: operand register (S1), full-width
// product register (S2) and accumulate (S3). A finished sum goes into a
// valid/ready output register and the next vector starts with no bubble.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, overrides everything
//   clr  - synchronous flush of pipeline, accumulator and element counter
//   bus  - mac_vec_pipe_if.slave (in_vld/in_rdy/in1/in2, out_vld/out_rdy/out_data/out_ovf)
// Optional feature macro: MAC_VEC_SAT_EN
//   defined   - each accumulate saturates on signed overflow and a sticky
//               per-vector flag is reported on out_ovf with the result
//   undefined - sums wrap modulo 2^ACC_W and out_ovf stays 0
module mac_vec_pipe #(
    parameter int IN_W    = 8,
    parameter int ACC_W   = 26,
    parameter int VEC_LEN = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    mac_vec_pipe_if.slave  bus
);
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    logic                      s1Vld_q,   s1Vld_d;
    logic signed [IN_W-1:0]    opA_q,     opA_d;
    logic signed [IN_W-1:0]    opB_q,     opB_d;
    logic                      s2Vld_q,   s2Vld_d;
    logic signed [2*IN_W-1:0]  prod_q,    prod_d;
    logic signed [ACC_W-1:0]   acc_q,     acc_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic                      ovfFlag_q, ovfFlag_d;
    logic                      outVld_q,  outVld_d;
    logic signed [ACC_W-1:0]   outData_q, outData_d;
    logic                      outOvf_q,  outOvf_d;

    logic                      stall;
    logic                      inRdy;
    logic                      accept;
    logic signed [ACC_W-1:0]   prodExt;
    logic signed [ACC_W-1:0]   rawSum;
    logic signed [ACC_W-1:0]   accSum;
    logic                      addOvf;

    // A result that downstream has not taken freezes the whole pipeline;
    // clr also refuses new pairs so the flush cannot lose an accepted one.
    assign stall  = outVld_q & ~bus.out_rdy;
    assign inRdy  = ~stall & ~clr;
    assign accept = bus.in_vld & inRdy;

    assign bus.in_rdy   = inRdy;
    assign bus.out_vld  = outVld_q;
    assign bus.out_data = outData_q;
    assign bus.out_ovf  = outOvf_q;

    // S3 adder: the product is sign-extended to the accumulator width.
    // With saturation, an overflow (equal operand signs, different sum sign)
    // clamps toward the sign of the accumulator operand.
    assign prodExt = ACC_W'(prod_q);
    assign rawSum  = acc_q + prodExt;

`ifdef MAC_VEC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    assign addOvf = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) &&
                    (rawSum[ACC_W-1] != acc_q[ACC_W-1]);
    assign accSum = addOvf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : rawSum;
`else
    assign addOvf = 1'b0;
    assign accSum = rawSum;
`endif

    // Next-state logic. The output handshake is evaluated first so that a
    // result written on the same edge as a consumed one overrides the drop
    // of out_vld. Pending output is left alone by clr.
    always_comb begin
        s1Vld_d   = s1Vld_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        s2Vld_d   = s2Vld_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovfFlag_d = ovfFlag_q;
        outVld_d  = outVld_q;
        outData_d = outData_q;
        outOvf_d  = outOvf_q;

        if (outVld_q && bus.out_rdy) begin
            outVld_d = 1'b0;
        end

        if (clr) begin
            s1Vld_d   = 1'b0;
            s2Vld_d   = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            ovfFlag_d = 1'b0;
        end else if (!stall) begin
            s1Vld_d = accept;
            if (accept) begin
                opA_d = bus.in1;
                opB_d = bus.in2;
            end

            s2Vld_d = s1Vld_q;
            if (s1Vld_q) begin
                prod_d = (2*IN_W)'(opA_q) * (2*IN_W)'(opB_q);
            end

            if (s2Vld_q) begin
                if (cnt_q == LAST_IDX) begin
                    outData_d = accSum;
                    outVld_d  = 1'b1;
                    outOvf_d  = ovfFlag_q | addOvf;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovfFlag_d = 1'b0;
                end else begin
                    acc_d     = accSum;
                    cnt_d     = cnt_q + CNT_W'(1);
                    ovfFlag_d = ovfFlag_q | addOvf;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Vld_q   <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            s2Vld_q   <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovfFlag_q <= 1'b0;
            outVld_q  <= 1'b0;
            outData_q <= '0;
            outOvf_q  <= 1'b0;
        end else begin
            s1Vld_q   <= s1Vld_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            s2Vld_q   <= s2Vld_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovfFlag_q <= ovfFlag_d;
            outVld_q  <= outVld_d;
            outData_q <= outData_d;
            outOvf_q  <= outOvf_d;
        end
    end
endmodule

// File: tb/tb_mac_vec_pipe.sv
// tb_mac_vec_pipe
// Directed bench for mac_vec_pipe with VEC_LEN=4. A 26-bit accumulator
// instance carries the main checks; a 16-bit instance sees the same stimulus
// and is checked on the -128*-128 vector, whose expected value depends on
// MAC_VEC_SAT_EN.
module tb_mac_vec_pipe;
    logic clk;
    logic rst;
    logic clr;
    int   checks;
    int   errors;

    mac_vec_pipe_if #(.IN_W(8), .ACC_W(26)) bus ();
    mac_vec_pipe_if #(.IN_W(8), .ACC_W(16)) bus16 ();

    // The narrow instance follows the main stimulus exactly.
    assign bus16.in_vld  = bus.in_vld;
    assign bus16.in1     = bus.in1;
    assign bus16.in2     = bus.in2;
    assign bus16.out_rdy = bus.out_rdy;

    mac_vec_pipe #(.IN_W(8), .ACC_W(26), .VEC_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    mac_vec_pipe #(.IN_W(8), .ACC_W(16), .VEC_LEN(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus16)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

`ifdef MAC_VEC_SAT_EN
    localparam int NARROW_EXP = 32767;
    localparam bit NARROW_OVF = 1'b1;
`else
    localparam int NARROW_EXP = 0;
    localparam bit NARROW_OVF = 1'b0;
`endif

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one pair and hold it for one edge.
    task automatic applyStimulus(input bit vld, input int a, input int b);
        bus.in_vld = vld;
        bus.in1    = 8'(a);
        bus.in2    = 8'(b);
        step();
    endtask

    // Present one pair until it is accepted (bounded), then drop in_vld.
    task automatic sendPair(input int a, input int b);
        int tries;
        tries      = 0;
        bus.in_vld = 1'b1;
        bus.in1    = 8'(a);
        bus.in2    = 8'(b);
        while (!bus.in_rdy && tries < 20) begin
            step();
            tries++;
        end
        if (!bus.in_rdy) checkOutput("accept_timeout", bus.in_rdy, 1);
        step();
        bus.in_vld = 1'b0;
    endtask

    task automatic sendVector(input int a, input int b);
        for (int i = 0; i < 4; i++) sendPair(a, b);
    endtask

    // Wait (bounded) for out_vld, check the result, then let one edge pass.
    task automatic waitResult(input string tag, input int expData, input bit expOvf,
                              input bit chkNarrow, input int expNarrow,
                              input bit expNarrowOvf);
        int n;
        n = 0;
        while (!bus.out_vld && n < 20) begin
            step();
            n++;
        end
        checkOutput({tag, "_vld"},  bus.out_vld,  1);
        checkOutput({tag, "_data"}, bus.out_data, expData);
        checkOutput({tag, "_ovf"},  bus.out_ovf,  32'(expOvf));
        if (chkNarrow) begin
            checkOutput({tag, "_w16_vld"},  bus16.out_vld,  1);
            checkOutput({tag, "_w16_data"}, bus16.out_data, expNarrow);
            checkOutput({tag, "_w16_ovf"},  bus16.out_ovf,  32'(expNarrowOvf));
        end
        step();
    endtask

    // Directed sequence.
    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        clr         = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in1     = '0;
        bus.in2     = '0;
        bus.out_rdy = 1'b1;
        step();
        step();
        checkOutput("por_vld",  bus.out_vld,  0);
        checkOutput("por_data", bus.out_data, 0);
        checkOutput("por_ovf",  bus.out_ovf,  0);
        checkOutput("por_rdy",  bus.in_rdy,   1);
        rst = 1'b0;

        $display("[TB] basic 3*4 and latency");
        sendVector(3, 4);
        checkOutput("basic_lat0", bus.out_vld, 0);
        step();
        checkOutput("basic_lat1", bus.out_vld, 0);
        step();
        checkOutput("basic_vld",  bus.out_vld,  1);
        checkOutput("basic_data", bus.out_data, 48);
        checkOutput("basic_ovf",  bus.out_ovf,  0);
        step();
        checkOutput("basic_drop", bus.out_vld,  0);
        checkOutput("basic_hold", bus.out_data, 48);

        $display("[TB] reset mid-vector");
        sendPair(7, 7);
        sendPair(7, 7);
        rst = 1'b1;
        step();
        step();
        checkOutput("mid_rst_vld",  bus.out_vld,  0);
        checkOutput("mid_rst_data", bus.out_data, 0);
        checkOutput("mid_rst_ovf",  bus.out_ovf,  0);
        checkOutput("mid_rst_rdy",  bus.in_rdy,   1);
        rst = 1'b0;
        sendVector(1, 1);
        waitResult("after_rst", 4, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] signed extremes");
        sendVector(-128, -128);
        waitResult("ext_pos", 65536, 1'b0, 1'b1, NARROW_EXP, NARROW_OVF);
        sendVector(-128, 127);
        waitResult("ext_neg", -65024, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] back-to-back vectors");
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_rdy", bus.in_rdy, 1);
            if (i < 4) sendPair(1, 1);
            else       sendPair(2, -3);
            if (i == 5) begin
                checkOutput("b2b_first_vld",  bus.out_vld,  1);
                checkOutput("b2b_first_data", bus.out_data, 4);
            end
        end
        waitResult("b2b_second", -24, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] backpressure");
        bus.out_rdy = 1'b0;
        sendVector(2, 2);
        sendPair(5, 5);
        sendPair(5, 5);
        bus.in_vld = 1'b1;
        bus.in1    = 8'sd5;
        bus.in2    = 8'sd5;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_rdy", bus.in_rdy,   0);
            checkOutput("bp_vld",    bus.out_vld,  1);
            checkOutput("bp_data",   bus.out_data, 16);
            step();
        end
        bus.out_rdy = 1'b1;
        #1;
        checkOutput("bp_release_rdy", bus.in_rdy, 1);
        step();
        sendPair(5, 5);
        waitResult("bp_next", 100, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] clr mid-vector");
        sendPair(7, 7);
        sendPair(7, 7);
        clr = 1'b1;
        bus.in_vld = 1'b1;
        bus.in1    = 8'sd9;
        bus.in2    = 8'sd9;
        #1;
        checkOutput("clr_in_rdy", bus.in_rdy, 0);
        step();
        clr = 1'b0;
        applyStimulus(1'b0, 0, 0);
        sendVector(5, 5);
        waitResult("after_clr", 100, 1'b0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_vec_pipe.md
Name: mac_vec_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate engine for dot products.
- Accepts one in1/in2 element pair per cycle under a valid/ready handshake and accumulates VEC_LEN products.
- Emits one result per vector through a valid/ready output register, then restarts accumulation with no bubble.
- Successor to the fixed 8-bit free-running MAC: adds width/length parameters, handshakes, vector framing, backpressure and optional saturation.

Parameters:
- IN_W, 8, signed operand width.
- ACC_W, 26, signed accumulator and result width; must be >= 2*IN_W.
- VEC_LEN, 16, products per result; must be >= 1; element counter width is clog2(VEC_LEN), minimum 1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous flush of pipeline, accumulator and element counter.
- in_vld  input  1  in1/in2 pair valid.
- in_rdy  output  1  block can accept a pair this cycle.
- in1  input  IN_W  signed operand A.
- in2  input  IN_W  signed operand B.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream accepts result.
- out_data  output  ACC_W  signed dot-product result.
- out_ovf  output  1  overflow occurred in this vector (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge): all valid bits, accumulator, counter, out_data, out_vld and out_ovf go to 0; in_rdy=1 the cycle after. rst overrides clr and all other inputs.
- stall = out_vld & ~out_rdy. in_rdy = ~stall & ~clr.
- While stall=1, every pipeline register, the accumulator and the counter hold.
- Pipeline stages:
  - S1: operand registers plus valid bit; loaded on accept (in_vld & in_rdy).
  - S2: full 2*IN_W signed product register plus valid bit.
  - S3: accumulate. Product is sign-extended to ACC_W; acc_next = acc + prod_ext.
- Latency: a pair accepted at edge E is accumulated at edge E+2. If it is the VEC_LEN-th element, out_data/out_vld update at edge E+2.
- Counter: increments on each S3 accumulate.
- At the VEC_LEN-th accumulate:
  - out_data <= acc + prod_ext; out_vld <= 1; out_ovf <= vector overflow flag.
  - acc <= 0; counter <= 0; flag <= 0.
  - The next vector's first product is accumulated on the following enabled edge with no bubble.
- Output handshake:
  - out_vld falls after an edge with out_rdy=1, unless a new result is written on that same edge. In that case out_vld stays 1 and out_data takes the new value.
  - out_data holds its last value when out_vld=0.
- clr=1 at edge (rst=0):
  - S1/S2 valid bits, accumulator, counter and overflow flag go to 0.
  - A pair presented that cycle is not accepted, since in_rdy=0.
  - Pending out_vld/out_data/out_ovf are untouched and still await out_rdy.
- Arithmetic: two's complement throughout. Without the optional feature, the ACC_W sum wraps modulo 2^ACC_W.
- Invalid bubbles (in_vld=0) propagate as S1/S2 valid=0 and do not change acc or counter.

Optional Feature:
- Macro: MAC_VEC_SAT_EN.
- Defined:
  - Each S3 addition detects signed overflow (operand signs equal, sum sign differs).
  - On overflow the sum clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)). Later products accumulate from the clamped value.
  - A sticky per-vector flag sets and is reported on out_ovf with that vector's result.
- Undefined: no detection, no clamping; sum wraps; out_ovf is constant 0.

Test Plan:
- Reset: rst=1 for 2 cycles mid-vector -> out_vld=0, out_data=0, out_ovf=0, in_rdy=1. Next vector with VEC_LEN=4 and all 1*1 gives 4, proving counter and accumulator reset.
- Basic (VEC_LEN=4, out_rdy=1): four pairs 3*4 back-to-back -> out_data=48, out_vld high exactly 2 edges after the 4th accept.
- Signed extremes (IN_W=8, ACC_W=26, VEC_LEN=4):
  - four pairs of -128*-128 -> 65536;
  - four pairs of -128*127 -> -65024.
- Back-to-back vectors: 8 continuous pairs, four of 1*1 then four of 2*-3 -> results 4 then -24 on consecutive output handshakes, with no input bubble.
- Backpressure: hold out_rdy=0 when the result is valid -> in_rdy=0 and out_data stable for 5 cycles while the pipeline holds. After out_rdy=1 the next vector (four of 5*5) gives 100.
- clr and saturation:
  - clr after 2 of 4 elements, then four of 5*5 -> 100 (out_ovf=0).
  - With ACC_W=16, four of -128*-128 -> 32767 and out_ovf=1 when MAC_VEC_SAT_EN is defined; 0 and out_ovf=0 when it is not.
